// File: rtl/regfile_dbg_ctrl.sv
// rtl/regfile_dbg_ctrl.sv - debug-side initiator for the integer register file
module regfile_dbg_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [ADDR_W-1:0] rsp_addr_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_last_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] rf_rs1_addr_o,
    input  logic [DATA_W-1:0] rf_rs1_data_i,
    output logic [ADDR_W-1:0] rf_rd_addr_o,
    output logic [DATA_W-1:0] rf_rd_data_o,
    output logic              rf_rd_wren_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RSP     = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // One extra bit so the terminal index is compared without wrapping to zero.
    localparam logic [ADDR_W:0] LAST_IDX  = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_last_q, rsp_last_d;

    logic                cmd_fire;
    logic                idx_at_last;
    logic [ADDR_W-1:0]   cur_addr;

    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign idx_at_last = (idx_q == LAST_IDX);
    // READ targets the latched address; DUMP walks the index counter.
    assign cur_addr    = (op_q == OP_DUMP) ? idx_q[ADDR_W-1:0] : addr_q;

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: sequencing of write, read, dump and clear operations.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op_i)
                        OP_WRITE: state_d = S_WRITE;
                        OP_READ:  state_d = S_RD_ADDR;
                        OP_DUMP:  state_d = S_RD_ADDR;
                        default:  state_d = S_CLEAR;
                    endcase
                end
            end
            S_WRITE:   state_d = S_IDLE;
            S_RD_ADDR: state_d = S_RSP;
            S_RSP: begin
                if (rsp_ready_i) begin
                    state_d = (op_q == OP_DUMP && !rsp_last_q) ? S_RD_ADDR : S_IDLE;
                end
            end
            S_CLEAR: begin
                if (idx_at_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: command latch, index counter and response capture.
    always_comb begin
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        rsp_addr_d = rsp_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_last_d = rsp_last_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    op_d   = cmd_op_i;
                    addr_d = cmd_addr_i;
                    data_d = cmd_data_i;
                    idx_d  = (cmd_op_i == OP_CLEAR) ? IDX_ONE : '0;
                end
            end
            S_RD_ADDR: begin
                rsp_addr_d = cur_addr;
                // x0 reads as zero whatever the regfile drives.
                rsp_data_d = (cur_addr == '0) ? '0 : rf_rs1_data_i;
                rsp_last_d = (op_q != OP_DUMP) || idx_at_last;
            end
            S_RSP: begin
                if (rsp_ready_i && op_q == OP_DUMP && !rsp_last_q) begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            S_CLEAR: begin
                idx_d = idx_q + IDX_ONE;
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Datapath registers; reset clears any pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q       <= OP_WRITE;
            addr_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_last_q <= rsp_last_d;
        end
    end

    // Output decode from the current state.
    always_comb begin
        cmd_ready_o   = (state_q == S_IDLE) && !rst_i;
        busy_o        = (state_q != S_IDLE);
        rsp_valid_o   = (state_q == S_RSP);
        rsp_last_o    = (state_q == S_RSP) && rsp_last_q;
        rsp_addr_o    = rsp_addr_q;
        rsp_data_o    = rsp_data_q;
        rf_rs1_addr_o = '0;
        rf_rd_addr_o  = '0;
        rf_rd_data_o  = '0;
        rf_rd_wren_o  = 1'b0;
        case (state_q)
            S_RD_ADDR: begin
                rf_rs1_addr_o = cur_addr;
            end
            S_WRITE: begin
                rf_rd_addr_o = addr_q;
                rf_rd_data_o = data_q;
                rf_rd_wren_o = (addr_q != '0);
            end
            S_CLEAR: begin
                rf_rd_addr_o = idx_q[ADDR_W-1:0];
                rf_rd_data_o = '0;
                rf_rd_wren_o = 1'b1;
            end
            default: begin
                rf_rd_wren_o = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/regfile_dbg_ctrl.md
Name: regfile_dbg_ctrl

Overview:
Debug-side initiator for the 32x32 integer register file: drives the regfile write port (rd addr/data/wren) and one read-port address (rs1 addr), and consumes its read data. Accepts single-beat commands over a valid/ready stream (write one, read one, dump all, clear all) and returns read results over a valid/ready response stream. While busy_o is high, the core-side mux gives the regfile ports to this block; the core is stalled externally.

Parameters:
ADDR_W, 5, register address width; register count is 2**ADDR_W
DATA_W, 32, register data width

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_op_i  in  2  00 WRITE, 01 READ, 10 DUMP, 11 CLEAR
cmd_addr_i  in  ADDR_W  target register (WRITE/READ only)
cmd_data_i  in  DATA_W  write data (WRITE only)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_addr_o  out  ADDR_W  register index of response
rsp_data_o  out  DATA_W  register contents
rsp_last_o  out  1  final beat of READ or DUMP
busy_o  out  1  block owns regfile ports
rf_rs1_addr_o  out  ADDR_W  regfile read address
rf_rs1_data_i  in  DATA_W  regfile read data (combinational)
rf_rd_addr_o  out  ADDR_W  regfile write address
rf_rd_data_o  out  DATA_W  regfile write data
rf_rd_wren_o  out  1  regfile write enable

Behaviour:
- Reset: state IDLE; cmd_ready_o=0 during the reset cycle, 1 from the first non-reset IDLE cycle; rsp_valid_o=0, rsp_last_o=0, rsp_addr_o=0, rsp_data_o=0, busy_o=0, rf_rd_wren_o=0, all rf address/data outputs 0.
- Reset mid-operation: next cycle is IDLE; any pending response is dropped; wren deasserted; a partial CLEAR/DUMP is not resumed.
- States: IDLE, WRITE, RD_ADDR, RSP, CLEAR.
- cmd_ready_o=1 only in IDLE. busy_o=1 in every state except IDLE. Command fields are latched at acceptance; later input changes are ignored.
- WRITE (accepted cycle T): in T+1 drive rf_rd_addr_o/rf_rd_data_o from the latched command and rf_rd_wren_o=1 for exactly one cycle, then IDLE at T+2. addr 0: wren stays 0 (x0 is never written); the command still completes in the same time.
- READ: T+1 RD_ADDR drives rf_rs1_addr_o=addr and captures rf_rs1_data_i at the end of the cycle; T+2 RSP, rsp_valid_o=1, rsp_last_o=1. Response of addr 0 is 0 regardless of rf_rs1_data_i.
- RSP: rsp_* held stable while rsp_valid_o && !rsp_ready_i; on handshake, rsp_valid_o drops next cycle (READ -> IDLE) or DUMP advances.
- DUMP: index i runs 0..2**ADDR_W-1, each RD_ADDR -> RSP pair; rsp_last_o=1 only when i is the last index; after last handshake -> IDLE. Minimum 2 cycles per beat; backpressure stretches RSP only.
- CLEAR: index runs 1..2**ADDR_W-1, one write per cycle, rf_rd_data_o=0, wren=1 (31 cycles at default); then IDLE. No responses.
- rf_rd_wren_o is 1 only in WRITE (addr!=0) and CLEAR; never in other states.
- Index counter ADDR_W+1 bits wide to detect the terminal count without wrap-around aliasing.
- Write-then-read: a READ accepted at the earliest cycle after a WRITE (T+2) returns the newly written value.

Test Plan:
- Reset then WRITE addr 5 data 0xDEADBEEF -> wren=1 for one cycle with rd_addr=5; READ addr 5 -> rsp_data=0xDEADBEEF, rsp_addr=5, last=1, rsp_valid two cycles after acceptance.
- WRITE addr 0 data 0x12345678 -> wren never asserts; READ addr 0 -> rsp_data=0 even if the regfile model drives 0xFFFFFFFF.
- Preload x1..x31 = index*0x11111111 (truncated), DUMP with rsp_ready_i toggling randomly -> 32 in-order beats, addr 0..31, correct data, rsp_* stable under backpressure, last only on addr 31.
- CLEAR -> exactly 31 consecutive wren cycles, rd_addr 1..31, data 0; subsequent DUMP returns all zeros; busy_o high throughout.
- Assert rst_i at beat 10 of a DUMP -> next cycle rsp_valid_o=0, busy_o=0; a new READ addr 3 then completes normally.
- Hold cmd_valid_i high continuously during a DUMP -> cmd_ready_o stays 0 until IDLE; the queued command is accepted on the first IDLE cycle.
